// File: rtl/dsp_acc_pkg.sv
// rtl/dsp_acc_pkg.sv - shared widths, mode bit positions and saturation limits
package dsp_acc_pkg;

   // Default datapath widths
   localparam int DEF_A_W   = 10;
   localparam int DEF_B_W   = 9;
   localparam int DEF_ACC_W = 24;

   // Bit positions of the mode bits inside the configuration word
   localparam int CFG_IN_REG_BIT = 0;
   localparam int CFG_ACC_EN_BIT = 1;
   localparam int CFG_SAT_BIT    = 2;
   localparam int CFG_SR_SET_BIT = 3;
   localparam int CFG_W          = 4;

   // Largest positive value of a w-bit signed number, in a 64-bit container
   function automatic logic [63:0] sat_max(input int w);
      sat_max = (64'd1 << (w - 1)) - 64'd1;
   endfunction

   // Most negative value of a w-bit signed number, in a 64-bit container
   function automatic logic [63:0] sat_min(input int w);
      sat_min = ~sat_max(w);
   endfunction

endpackage

// File: rtl/dsp_acc_sat_add.sv
// rtl/dsp_acc_sat_add.sv - signed accumulator adder with optional saturation
module dsp_acc_sat_add
   import dsp_acc_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [ACC_W-1:0] addend,
   input  logic             sat_en,
   output logic [ACC_W-1:0] sum,
   output logic             ovf_pulse
);

   localparam logic [63:0]      W_MAX   = sat_max(ACC_W);
   localparam logic [63:0]      W_MIN   = sat_min(ACC_W);
   localparam logic [ACC_W-1:0] SAT_MAX = W_MAX[ACC_W-1:0];
   localparam logic [ACC_W-1:0] SAT_MIN = W_MIN[ACC_W-1:0];

   logic [ACC_W-1:0] w_raw;

   assign w_raw = acc + addend;

   // Overflow: operands share a sign but the wrapped result does not; clamp
   // towards the operands' sign when saturation is enabled
   always_comb begin
      ovf_pulse = (acc[ACC_W-1] == addend[ACC_W-1]) && (w_raw[ACC_W-1] != acc[ACC_W-1]);
      sum       = w_raw;
      if (ovf_pulse && sat_en) begin
         sum = acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
      end
   end

endmodule

// File: rtl/dsp_acc_reg_stage.sv
// rtl/dsp_acc_reg_stage.sv - registered multiply-accumulate stage of the DSP tile
module dsp_acc_reg_stage
   import dsp_acc_pkg::*;
#(
   parameter int A_W   = DEF_A_W,
   parameter int B_W   = DEF_B_W,
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sr_i,
   input  logic             ce,
   input  logic             in_vld,
   input  logic [A_W-1:0]   a,
   input  logic [B_W-1:0]   b,
   input  logic             cfg_in_reg,
   input  logic             cfg_acc_en,
   input  logic             cfg_sat,
   input  logic             cfg_sr_set,
   output logic [ACC_W-1:0] z,
   output logic             out_vld,
   output logic             ovf
);

   localparam int P_W = A_W + B_W;

   logic [CFG_W-1:0]        w_cfg;
   logic signed [A_W-1:0]   r_a_q;
   logic signed [B_W-1:0]   r_b_q;
   logic                    r_v1;
   logic signed [P_W-1:0]   r_p_q;
   logic                    r_v2;
   logic [ACC_W-1:0]        r_acc_q;
   logic                    r_out_vld;
   logic                    r_ovf;

   logic signed [A_W-1:0]   w_ma;
   logic signed [B_W-1:0]   w_mb;
   logic signed [P_W-1:0]   w_prod;
   logic signed [ACC_W-1:0] w_p_ext;
   logic [ACC_W-1:0]        w_sum;
   logic                    w_ovf_pulse;

   // Static mode bits gathered into the configuration word layout
   assign w_cfg[CFG_IN_REG_BIT] = cfg_in_reg;
   assign w_cfg[CFG_ACC_EN_BIT] = cfg_acc_en;
   assign w_cfg[CFG_SAT_BIT]    = cfg_sat;
   assign w_cfg[CFG_SR_SET_BIT] = cfg_sr_set;

   assign w_ma    = w_cfg[CFG_IN_REG_BIT] ? r_a_q : a;
   assign w_mb    = w_cfg[CFG_IN_REG_BIT] ? r_b_q : b;
   assign w_prod  = P_W'(w_ma) * P_W'(w_mb);
   assign w_p_ext = ACC_W'(r_p_q);

   dsp_acc_sat_add #(
      .ACC_W (ACC_W)
   ) u_sat_add (
      .acc       (r_acc_q),
      .addend    (w_p_ext),
      .sat_en    (w_cfg[CFG_SAT_BIT]),
      .sum       (w_sum),
      .ovf_pulse (w_ovf_pulse)
   );

   // Pipeline registers: reset beats local set/reset, which beats clock enable
   always_ff @(posedge clk) begin
      if (reset || (sr_i && !w_cfg[CFG_SR_SET_BIT])) begin
         r_a_q     <= '0;
         r_b_q     <= '0;
         r_v1      <= 1'b0;
         r_p_q     <= '0;
         r_v2      <= 1'b0;
         r_acc_q   <= '0;
         r_out_vld <= 1'b0;
         r_ovf     <= 1'b0;
      end else if (sr_i) begin
         r_a_q     <= '0;
         r_b_q     <= '0;
         r_v1      <= 1'b0;
         r_p_q     <= '0;
         r_v2      <= 1'b0;
         r_acc_q   <= '1;
         r_out_vld <= 1'b0;
         r_ovf     <= 1'b0;
      end else if (ce) begin
         if (w_cfg[CFG_IN_REG_BIT]) begin
            r_a_q <= a;
            r_b_q <= b;
            r_v1  <= in_vld;
         end
         r_p_q     <= w_prod;
         r_v2      <= w_cfg[CFG_IN_REG_BIT] ? r_v1 : in_vld;
         r_out_vld <= r_v2;
         if (w_cfg[CFG_ACC_EN_BIT]) begin
            r_acc_q <= w_sum;
            r_ovf   <= r_ovf | w_ovf_pulse;
         end else begin
            r_acc_q <= w_p_ext;
         end
      end
   end

   assign z       = r_acc_q;
   assign out_vld = r_out_vld;
   assign ovf     = r_ovf;

endmodule

// File: doc/dsp_acc_reg_stage.md
Name: dsp_acc_reg_stage

Overview:
Registered multiply-accumulate stage of the DSP logical tile. It sits directly downstream of the DSP set/reset option stage and consumes that stage's polarity-selected output as its local synchronous set/reset.
It registers operands and product, then accumulates or loads into an output register. Mode bits come from configuration memory as static inputs.
The stage supports optional saturation and has a sticky overflow flag.

Parameters:
A_W, 10, signed operand A width
B_W, 9, signed operand B width
ACC_W, 24, signed accumulator/output width (must be >= A_W+B_W)

Ports:
clk  input  1  fabric user clock; all state updates on its rising edge
reset  input  1  global reset; synchronous, active-high
sr_i  input  1  local set/reset from the set/reset option stage output; synchronous, active-high
ce  input  1  clock enable for all datapath and valid registers
in_vld  input  1  operand-valid tag
a  input  A_W  signed operand A
b  input  B_W  signed operand B
cfg_in_reg  input  1  1: register a/b before the multiplier; 0: bypass
cfg_acc_en  input  1  1: accumulate; 0: load product
cfg_sat  input  1  1: saturate on overflow; 0: two's-complement wrap
cfg_sr_set  input  1  0: sr_i clears; 1: sr_i sets
z  output  ACC_W  accumulator register value
out_vld  output  1  z holds a result of valid input
ovf  output  1  sticky overflow flag

Behaviour:
- Reset: when reset=1 at an edge, a_q, b_q, p_q, acc_q, all valid bits and ovf become 0. z=0, out_vld=0, ovf=0.
- Priority per edge: reset > sr_i > ce.
- sr_i=1 (reset=0) with cfg_sr_set=0: all registers and flags cleared, same as reset.
- sr_i=1 with cfg_sr_set=1: acc_q set to all-ones (z = -1). a_q, b_q, p_q, valid bits and ovf cleared.
- ce=0 (reset=0, sr_i=0): every register holds.
- Pipeline, applied when ce=1:
  - if cfg_in_reg: a_q<=a, b_q<=b, v1<=in_vld.
  - p_q <= signed(mA)*signed(mB), where mA/mB = a_q/b_q if cfg_in_reg, else a/b. Product width A_W+B_W. v2 <= (cfg_in_reg ? v1 : in_vld).
  - acc_q <= cfg_acc_en ? acc_q + sext(p_q) : sext(p_q). out_vld <= v2.
- Accumulation does not depend on the valid tag; the valid bits are tracking only.
- Latency from a/b sample to z: 3 ce-qualified edges with cfg_in_reg=1, 2 with cfg_in_reg=0.
- Overflow is detected on the signed ACC_W add: operand signs equal and result sign different. Load mode never overflows.
  - cfg_sat=1: result clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - cfg_sat=0: result wraps.
  - Either way, ovf<=1 and stays set until reset or sr_i.
- Configuration inputs are static during operation. A change takes effect at the next edge; results in flight are not guaranteed coherent.
- No combinational path from any input to any output.

Decomposition:
- Package dsp_acc_pkg holds:
  - the default width constants;
  - the mode bit-position constants for the configuration word;
  - sat_max/sat_min constant functions of ACC_W.
- One sub-module, dsp_acc_sat_add: combinational ACC_W signed adder. Inputs acc, addend, sat_en; outputs sum and ovf_pulse.

Test Plan:
1. reset, then cfg_in_reg=1, cfg_acc_en=0, ce=1; a=3, b=-4, in_vld pulse for 1 cycle -> z=-12 and out_vld=1 exactly at the 3rd edge after the sample; out_vld=0 at the 4th edge.
2. cfg_acc_en=1, cfg_in_reg=0; a=5, b=7 held for 4 cycles from acc=0 -> z sequence 35, 70, 105, 140 starting at the 2nd edge; ovf=0.
3. cfg_sat=1, cfg_acc_en=1; a=-512, b=-256 (product 131072) held continuously -> z reaches 8388607 on the 64th accumulate and holds; ovf=1. Same stimulus with cfg_sat=0 -> z = -8388608, ovf=1.
4. Mid-stream sr_i=1 with cfg_sr_set=0 -> next edge z=0, out_vld=0, ovf=0. Repeat with cfg_sr_set=1 -> z = 0xFFFFFF (-1), ovf=0. Then resume accumulating 1*1 -> z goes 0, 1, 2 with cfg_sr_set=1.
5. ce=0 for 5 cycles mid-accumulation with operands changing -> z, out_vld and ovf are frozen. Resuming ce continues from the held state with no lost or duplicated sample.
6. reset=1 and sr_i=1 with cfg_sr_set=1 in the same cycle -> z=0, not -1; reset wins.
